// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C request sequencer: FSM states, response codes, command beat bits.
package i2c_seq_pkg;

    localparam int unsigned TMR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        CMD_W,
        TX_REG,
        TX_DAT,
        CMD_R,
        RX,
        DRAIN,
        RESP
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MACK    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } rsp_err_e;

    // Command beat as presented to the master's s_axis_cmd_* port group
    typedef struct packed {
        logic [6:0] address;
        logic       start;
        logic       read;
        logic       write;
        logic       write_multiple;
        logic       stop;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin grant selection: first valid requester at or after the pointer, wrapping.
module i2c_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [2:0]         idx_c,
    output logic               any_c
);

    logic [2:0] ptr;
    logic [3:0] cand;

    // Scan candidates ptr, ptr+1, ... (mod NUM_REQ) and take the first one that is requesting
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = 4'(ptr) + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!any_c && req[i] && (cand == 4'(i))) begin
                    grant_c[i] = 1'b1;
                    idx_c      = 3'(i);
                    any_c      = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the slot after the winner whenever a grant is taken
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ptr <= '0;
        end else if (advance && any_c) begin
            ptr <= (idx_c == 3'(NUM_REQ - 1)) ? 3'd0 : idx_c + 3'd1;
        end
    end

endmodule

// File: rtl/i2c_req_sequencer.sv
// Shares one I2C master among NUM_REQ clients: arbitrates, sequences cmd/tx/rx beats, returns one response per request.
module i2c_req_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_rnw,
    input  logic [7*NUM_REQ-1:0]   req_dev_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic [7:0]             rsp_rdata,
    output logic [1:0]             rsp_err,
    output logic [6:0]             cmd_address,
    output logic                   cmd_start,
    output logic                   cmd_read,
    output logic                   cmd_write,
    output logic                   cmd_write_multiple,
    output logic                   cmd_stop,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             tx_tdata,
    output logic                   tx_tvalid,
    output logic                   tx_tlast,
    input  logic                   tx_tready,
    input  logic [7:0]             rx_tdata,
    input  logic                   rx_tvalid,
    output logic                   rx_tready,
    input  logic                   i2c_busy,
    input  logic                   i2c_missed_ack
);

    seq_state_e         state;
    i2c_cmd_t           cmd_q;
    logic               rnw_q;
    logic [7:0]         reg_q;
    logic [7:0]         wdata_q;
    logic [TMR_W-1:0]   tmr;
    logic               drain_idle;
    logic               timeout_c;

    logic [NUM_REQ-1:0] grant_c;
    logic [2:0]         idx_c;
    logic               any_c;
    logic               sel_rnw;
    logic [6:0]         sel_dev;
    logic [7:0]         sel_reg;
    logic [7:0]         sel_wdata;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req_valid),
        .advance (state == IDLE),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    assign cmd_address        = cmd_q.address;
    assign cmd_start          = cmd_q.start;
    assign cmd_read           = cmd_q.read;
    assign cmd_write          = cmd_q.write;
    assign cmd_write_multiple = cmd_q.write_multiple;
    assign cmd_stop           = cmd_q.stop;

    assign timeout_c = (tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Mux the granted client's request fields
    always_comb begin
        sel_rnw   = 1'b0;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i]) begin
                sel_rnw   = req_rnw[i];
                sel_dev   = req_dev_addr[i*7 +: 7];
                sel_reg   = req_reg_addr[i*8 +: 8];
                sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // Transaction FSM; every output is a register updated on the transition into the state that drives it
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_NONE;
            cmd_q      <= '0;
            cmd_valid  <= 1'b0;
            tx_tdata   <= '0;
            tx_tvalid  <= 1'b0;
            tx_tlast   <= 1'b0;
            rx_tready  <= 1'b0;
            rnw_q      <= 1'b0;
            reg_q      <= '0;
            wdata_q    <= '0;
            tmr        <= '0;
            drain_idle <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= 1'b0;
            if (state != IDLE) begin
                tmr <= tmr + TMR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (any_c) begin
                        req_ready <= grant_c;
                        rsp_id    <= idx_c;
                        rsp_err   <= ERR_NONE;
                        rsp_rdata <= '0;
                        rnw_q     <= sel_rnw;
                        reg_q     <= sel_reg;
                        wdata_q   <= sel_wdata;
                        tmr       <= '0;
                        cmd_q     <= '{address: sel_dev, start: 1'b1, read: 1'b0, write: 1'b0,
                                       write_multiple: 1'b1, stop: ~sel_rnw};
                        cmd_valid <= 1'b1;
                        state     <= CMD_W;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    // Missed ACK is sticky and wins the error code over a same-cycle timeout
                    if (i2c_missed_ack) begin
                        rsp_err   <= ERR_MACK;
                        rsp_rdata <= '0;
                    end

                    if (timeout_c || (i2c_missed_ack && state != DRAIN)) begin
                        cmd_valid <= 1'b0;
                        cmd_q     <= '{address: cmd_q.address, start: 1'b0, read: 1'b0, write: 1'b0,
                                       write_multiple: 1'b0, stop: 1'b0};
                        tx_tvalid <= 1'b0;
                        tx_tlast  <= 1'b0;
                        tx_tdata  <= '0;
                        rx_tready <= 1'b0;
                    end

                    if (timeout_c) begin
                        if (!i2c_missed_ack && rsp_err == ERR_NONE) begin
                            rsp_err <= ERR_TIMEOUT;
                        end
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (i2c_missed_ack && state != DRAIN) begin
                        drain_idle <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        case (state)
                            CMD_W: begin
                                if (cmd_ready) begin
                                    cmd_valid <= 1'b0;
                                    cmd_q     <= '{address: cmd_q.address, start: 1'b0, read: 1'b0,
                                                   write: 1'b0, write_multiple: 1'b0, stop: 1'b0};
                                    tx_tvalid <= 1'b1;
                                    tx_tdata  <= reg_q;
                                    tx_tlast  <= rnw_q;
                                    state     <= TX_REG;
                                end
                            end
                            TX_REG: begin
                                if (tx_tready) begin
                                    if (rnw_q) begin
                                        tx_tvalid <= 1'b0;
                                        tx_tlast  <= 1'b0;
                                        tx_tdata  <= '0;
                                        cmd_q     <= '{address: cmd_q.address, start: 1'b1, read: 1'b1,
                                                       write: 1'b0, write_multiple: 1'b0, stop: 1'b1};
                                        cmd_valid <= 1'b1;
                                        state     <= CMD_R;
                                    end else begin
                                        tx_tdata <= wdata_q;
                                        tx_tlast <= 1'b1;
                                        state    <= TX_DAT;
                                    end
                                end
                            end
                            TX_DAT: begin
                                if (tx_tready) begin
                                    tx_tvalid  <= 1'b0;
                                    tx_tlast   <= 1'b0;
                                    tx_tdata   <= '0;
                                    drain_idle <= 1'b0;
                                    state      <= DRAIN;
                                end
                            end
                            CMD_R: begin
                                if (cmd_ready) begin
                                    cmd_valid <= 1'b0;
                                    cmd_q     <= '{address: cmd_q.address, start: 1'b0, read: 1'b0,
                                                   write: 1'b0, write_multiple: 1'b0, stop: 1'b0};
                                    rx_tready <= 1'b1;
                                    state     <= RX;
                                end
                            end
                            RX: begin
                                if (rx_tvalid) begin
                                    rsp_rdata  <= rx_tdata;
                                    rx_tready  <= 1'b0;
                                    drain_idle <= 1'b0;
                                    state      <= DRAIN;
                                end
                            end
                            DRAIN: begin
                                // Master busy lags the last beat, so require two idle samples in a row
                                if (i2c_busy) begin
                                    drain_idle <= 1'b0;
                                end else if (drain_idle) begin
                                    rsp_valid <= 1'b1;
                                    state     <= RESP;
                                end else begin
                                    drain_idle <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
